// File: rtl/ram_stream_reader_pkg.sv
// Shared types and constants for the RAM stream reader: FSM states, output FIFO
// geometry and the read credit limit.
package ram_stream_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int unsigned FIFO_DEPTH   = 4;
  localparam int unsigned FIFO_PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned FIFO_CNT_W   = FIFO_PTR_W + 1;
  localparam int unsigned CREDIT_LIMIT = 4;
  localparam int unsigned PEND_STAGES  = 2;
  localparam int unsigned CREDIT_W     = FIFO_CNT_W + 1;

  // Words already committed: buffered in the FIFO plus reads still in the RAM pipe.
  function automatic logic [CREDIT_W-1:0] credits_used(
    input logic [FIFO_CNT_W-1:0]  occ,
    input logic [PEND_STAGES-1:0] pend
  );
    return CREDIT_W'(occ) + CREDIT_W'(pend[0]) + CREDIT_W'(pend[1]);
  endfunction

endpackage

// File: rtl/ram_stream_reader_stream_fifo.sv
// Four-entry synchronous FIFO holding {LAST, DATA} words returned by the RAM.
// A push is accepted while full only if a pop happens on the same edge.
module stream_fifo
  import ram_stream_reader_pkg::*;
#(
  parameter int unsigned WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      wr_data,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [FIFO_CNT_W-1:0] count
);

  logic [WIDTH-1:0]      mem_q [FIFO_DEPTH];
  logic [WIDTH-1:0]      mem_d [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_CNT_W-1:0] count_q, count_d;
  logic                  do_push, do_pop;

  assign full    = (count_q == FIFO_CNT_W'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + FIFO_PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + FIFO_PTR_W'(1);
    end
    count_d = count_q + FIFO_CNT_W'(do_push) - FIFO_CNT_W'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ram_stream_reader.sv
// Walks a contiguous, wrapping address range through a one-cycle-latency RAM read
// port and presents the returned words as a valid/ready stream tagged with LAST.
module ram_stream_reader
  import ram_stream_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 2,
  parameter int unsigned ADDR_WIDTH = 2
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  START,
  input  logic [ADDR_WIDTH-1:0] BASE_ADDR,
  input  logic [ADDR_WIDTH:0]   LEN,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  EN_RD,
  output logic [ADDR_WIDTH-1:0] ADDR_RD,
  input  logic [DATA_WIDTH-1:0] D_RAM,
  output logic                  M_VALID,
  input  logic                  M_READY,
  output logic [DATA_WIDTH-1:0] M_DATA,
  output logic                  M_LAST
);

  localparam int unsigned LEN_W   = ADDR_WIDTH + 1;
  localparam int unsigned ENTRY_W = DATA_WIDTH + 1;

  state_e                 state_q, state_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   en_rd_q, en_rd_d;
  logic [ADDR_WIDTH-1:0]  addr_rd_q, addr_rd_d;
  logic [ADDR_WIDTH-1:0]  next_addr_q, next_addr_d;
  logic [LEN_W-1:0]       remaining_q, remaining_d;
  logic [PEND_STAGES-1:0] pend_q, pend_d;
  logic [PEND_STAGES-1:0] last_pipe_q, last_pipe_d;

  logic                   issue_c;
  logic                   issue_last_c;
  logic                   credit_ok_c;
  logic                   fifo_pop_c;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [FIFO_CNT_W-1:0]  fifo_count;
  logic [ENTRY_W-1:0]     fifo_rd;

  stream_fifo #(
    .WIDTH(ENTRY_W)
  ) u_fifo (
    .clk     (CLK),
    .rst_n   (RST_N),
    .push    (pend_q[1]),
    .pop     (fifo_pop_c),
    .wr_data ({last_pipe_q[1], D_RAM}),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign fifo_pop_c  = !fifo_empty && M_READY;
  assign credit_ok_c = !fifo_full &&
                       (credits_used(fifo_count, pend_q) < CREDIT_W'(CREDIT_LIMIT));

  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign EN_RD   = en_rd_q;
  assign ADDR_RD = addr_rd_q;
  assign M_VALID = !fifo_empty;
  assign M_DATA  = fifo_empty ? '0 : fifo_rd[DATA_WIDTH-1:0];
  assign M_LAST  = !fifo_empty && fifo_rd[DATA_WIDTH];

  // Next-state, read issue and credit control
  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    addr_rd_d    = addr_rd_q;
    next_addr_d  = next_addr_q;
    remaining_d  = remaining_q;
    issue_c      = 1'b0;
    issue_last_c = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (START) begin
          if (LEN == '0) begin
            done_d = 1'b1;
          end else begin
            busy_d       = 1'b1;
            issue_c      = 1'b1;
            addr_rd_d    = BASE_ADDR;
            next_addr_d  = BASE_ADDR + ADDR_WIDTH'(1);
            remaining_d  = LEN - LEN_W'(1);
            issue_last_c = (LEN == LEN_W'(1));
            state_d      = (LEN == LEN_W'(1)) ? ST_DRAIN : ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (credit_ok_c) begin
          issue_c     = 1'b1;
          addr_rd_d   = next_addr_q;
          next_addr_d = next_addr_q + ADDR_WIDTH'(1);
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) begin
            issue_last_c = 1'b1;
            state_d      = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (fifo_pop_c && fifo_rd[DATA_WIDTH]) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    en_rd_d     = issue_c;
    pend_d      = {pend_q[0], issue_c};
    last_pipe_d = {last_pipe_q[0], issue_last_c};
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      en_rd_q     <= 1'b0;
      addr_rd_q   <= '0;
      next_addr_q <= '0;
      remaining_q <= '0;
      pend_q      <= '0;
      last_pipe_q <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      en_rd_q     <= en_rd_d;
      addr_rd_q   <= addr_rd_d;
      next_addr_q <= next_addr_d;
      remaining_q <= remaining_d;
      pend_q      <= pend_d;
      last_pipe_q <= last_pipe_d;
    end
  end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Self-checking bench for ram_stream_reader: RAM model, table of transfers,
// reset and restart sequences, and randomized back-pressure against a queue model.
module tb_ram_stream_reader;

  localparam int unsigned DW    = 2;
  localparam int unsigned AW    = 2;
  localparam int          WORDS = 4;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          START;
  logic [AW-1:0] BASE_ADDR;
  logic [AW:0]   LEN;
  logic          BUSY, DONE, EN_RD;
  logic [AW-1:0] ADDR_RD;
  logic [DW-1:0] D_RAM = '0;
  logic          M_VALID, M_READY;
  logic [DW-1:0] M_DATA;
  logic          M_LAST;

  logic [DW-1:0] mem [WORDS];

  ram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .BASE_ADDR(BASE_ADDR), .LEN(LEN),
    .BUSY(BUSY), .DONE(DONE), .EN_RD(EN_RD), .ADDR_RD(ADDR_RD), .D_RAM(D_RAM),
    .M_VALID(M_VALID), .M_READY(M_READY), .M_DATA(M_DATA), .M_LAST(M_LAST)
  );

  always #5 CLK = ~CLK;

  // Registered read port of the RAM
  always @(posedge CLK) begin
    if (EN_RD) D_RAM <= mem[ADDR_RD];
  end

  typedef struct {
    logic [AW-1:0] base;
    logic [AW:0]   len;
    int            mode;       // 0 ready=1, 1 random ready, 2 stall 10 cycles
    int            restart;    // step at which a second START is driven, -1 none
    int            exp_beats;
    logic [DW-1:0] exp_first;
    logic [DW-1:0] exp_lastw;
    int            exp_done;   // step DONE is seen, -1 unchecked
  } vec_t;

  int            n_cmp = 0;
  int            n_err = 0;
  logic [DW-1:0] got_data [$];
  logic          got_last [$];
  int            beat_cyc [$];
  logic [AW-1:0] addr_q   [$];
  int            cyc, done_cnt, done_cyc, max_out, en_at10;
  logic          busy_seen, valid_seen, busy_at_done, prev_stall, en_rd_at10;
  logic [DW:0]   prev_word;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] exp_addr(input logic [AW-1:0] base, input int i);
    return AW'((int'(base) + i) % WORDS);
  endfunction

  task automatic clear_obs();
    got_data.delete(); got_last.delete(); beat_cyc.delete(); addr_q.delete();
    cyc = 0; done_cnt = 0; done_cyc = -1; max_out = 0; en_at10 = -1;
    busy_seen = 1'b0; valid_seen = 1'b0; busy_at_done = 1'b1; en_rd_at10 = 1'b1;
  endtask

  // Observe one cycle at the negedge (inputs already driven), then advance.
  task automatic step();
    int outstanding;
    if (prev_stall) check("stall_hold", 32'({M_VALID, M_LAST, M_DATA}), 32'({1'b1, prev_word}));
    prev_stall = M_VALID && !M_READY;
    prev_word  = {M_LAST, M_DATA};
    if (EN_RD) addr_q.push_back(ADDR_RD);
    outstanding = addr_q.size() - got_data.size();
    if (outstanding > max_out) max_out = outstanding;
    if (M_VALID && M_READY) begin
      got_data.push_back(M_DATA);
      got_last.push_back(M_LAST);
      beat_cyc.push_back(cyc);
    end
    if (DONE) begin
      done_cnt++;
      if (done_cyc < 0) begin
        done_cyc     = cyc;
        busy_at_done = BUSY;
      end
    end
    if (BUSY) busy_seen = 1'b1;
    if (M_VALID) valid_seen = 1'b1;
    @(negedge CLK);
    cyc++;
  endtask

  task automatic run_xfer(input logic [AW-1:0] base, input logic [AW:0] len,
                          input int mode, input int restart);
    clear_obs();
    BASE_ADDR = base;
    LEN       = len;
    START     = 1'b1;
    while (cyc < 200 && (done_cyc < 0 || cyc <= done_cyc + 2)) begin
      if (cyc > 0) begin
        START = (cyc == restart);
        if (cyc == restart) begin
          BASE_ADDR = 2'd1;
          LEN       = 3'd2;
        end
      end
      case (mode)
        0:       M_READY = 1'b1;
        1:       M_READY = 1'($urandom_range(0, 1));
        default: M_READY = (cyc > 10);
      endcase
      if (mode == 2 && cyc == 10) begin
        en_at10    = addr_q.size();
        en_rd_at10 = EN_RD;
      end
      step();
    end
    START = 1'b0;
  endtask

  // Compare the observed transfer against the queue model built from mem.
  task automatic verify_model(input logic [AW-1:0] base, input logic [AW:0] len, input string tag);
    int n;
    int nl;
    n  = int'(len);
    nl = 0;
    check({tag, "_beats"}, 32'(got_data.size()), 32'(n));
    for (int i = 0; i < n && i < got_data.size(); i++) begin
      check({tag, "_data"}, 32'(got_data[i]), 32'(mem[exp_addr(base, i)]));
      check({tag, "_last"}, 32'(got_last[i]), 32'(i == n - 1));
    end
    foreach (got_last[i]) if (got_last[i]) nl++;
    check({tag, "_nlast"}, 32'(nl), 32'(n > 0));
    check({tag, "_nreads"}, 32'(addr_q.size()), 32'(n));
    for (int i = 0; i < n && i < addr_q.size(); i++)
      check({tag, "_addr"}, 32'(addr_q[i]), 32'(exp_addr(base, i)));
    check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    check({tag, "_busy_at_done"}, 32'(busy_at_done), 32'd0);
    check({tag, "_busy_seen"}, 32'(busy_seen), 32'(n > 0));
    check({tag, "_valid_seen"}, 32'(valid_seen), 32'(n > 0));
    check({tag, "_credit"}, 32'(max_out <= 4), 32'd1);
  endtask

  vec_t vecs [8];

  initial begin
    vecs[0] = '{2'd0, 3'd4, 0, -1, 4, 2'd0, 2'd3, 7};
    vecs[1] = '{2'd2, 3'd3, 0, -1, 3, 2'd2, 2'd0, 6};
    vecs[2] = '{2'd3, 3'd2, 0, -1, 2, 2'd3, 2'd0, 5};
    vecs[3] = '{2'd1, 3'd1, 0, -1, 1, 2'd1, 2'd1, 4};
    vecs[4] = '{2'd0, 3'd0, 0, -1, 0, 2'd0, 2'd0, 1};
    vecs[5] = '{2'd0, 3'd4, 2, -1, 4, 2'd0, 2'd3, 15};
    vecs[6] = '{2'd0, 3'd4, 0,  2, 4, 2'd0, 2'd3, 7};
    vecs[7] = '{2'd1, 3'd4, 1, -1, 4, 2'd1, 2'd0, -1};

    for (int i = 0; i < WORDS; i++) mem[i] = DW'(i);
    RST_N = 1'b0; START = 1'b0; BASE_ADDR = '0; LEN = '0; M_READY = 1'b0;
    prev_stall = 1'b0; prev_word = '0;
    repeat (2) @(negedge CLK);
    check("reset_outputs", 32'({BUSY, DONE, EN_RD, ADDR_RD, M_VALID, M_DATA, M_LAST}), 32'd0);
    RST_N = 1'b1;
    @(negedge CLK);

    // Table-driven transfers over mem = 0,1,2,3
    for (int v = 0; v < 8; v++) begin
      string tag;
      tag = $sformatf("v%0d", v);
      run_xfer(vecs[v].base, vecs[v].len, vecs[v].mode, vecs[v].restart);
      verify_model(vecs[v].base, vecs[v].len, tag);
      if (vecs[v].exp_beats > 0 && got_data.size() == vecs[v].exp_beats) begin
        check({tag, "_first"}, 32'(got_data[0]), 32'(vecs[v].exp_first));
        check({tag, "_lastw"}, 32'(got_data[vecs[v].exp_beats - 1]), 32'(vecs[v].exp_lastw));
      end
      if (vecs[v].exp_done >= 0) check({tag, "_done_cyc"}, 32'(done_cyc), 32'(vecs[v].exp_done));
      if (vecs[v].mode == 0) begin
        for (int i = 0; i < beat_cyc.size(); i++)
          check({tag, "_beat_cyc"}, 32'(beat_cyc[i]), 32'(3 + i));
      end
      if (vecs[v].mode == 2) begin
        check({tag, "_reads_in_stall"}, 32'(en_at10), 32'd4);
        check({tag, "_en_rd_stalled"}, 32'(en_rd_at10), 32'd0);
      end
    end

    // Reset in the middle of a transfer, after two beats
    clear_obs();
    BASE_ADDR = 2'd0; LEN = 3'd4; START = 1'b1; M_READY = 1'b1;
    while (got_data.size() < 2 && cyc < 50) begin
      step();
      START = 1'b0;
    end
    check("rst_mid_beats", 32'(got_data.size()), 32'd2);
    RST_N = 1'b0;
    #1;
    check("rst_mid_outputs", 32'({BUSY, DONE, EN_RD, ADDR_RD, M_VALID, M_DATA, M_LAST}), 32'd0);
    prev_stall = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    clear_obs();
    repeat (5) step();
    check("rst_no_done", 32'(done_cnt), 32'd0);
    check("rst_no_reads", 32'(addr_q.size()), 32'd0);
    check("rst_no_valid", 32'(valid_seen), 32'd0);
    run_xfer(2'd3, 3'd1, 0, -1);
    verify_model(2'd3, 3'd1, "post_rst");

    // Randomized data, base and back-pressure
    for (int t = 0; t < 20; t++) begin
      logic [AW-1:0] b;
      for (int i = 0; i < WORDS; i++) mem[i] = DW'($urandom);
      b = AW'($urandom);
      run_xfer(b, 3'd4, 1, -1);
      verify_model(b, 3'd4, $sformatf("rnd%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
